// File: rtl/imem_sync_loader_if.sv
// Loader and fetch bus of the instruction memory.
// par_inj exists only when IMEM_PARITY_EN is defined.
interface imem_sync_loader_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 8
);
    logic          ld_start;
    logic          ld_valid;
    logic [W-1:0]  ld_data;
    logic          ld_last;
    logic [AW:0]   ld_count;
    logic          ld_err;
    logic          busy;
    logic          req;
    logic [AW-1:0] addr;
    logic          stall;
    logic [W-1:0]  ins;
    logic          ins_valid;
    logic          ins_perr;
`ifdef IMEM_PARITY_EN
    logic          par_inj;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, req, addr, stall, par_inj,
        input  ld_count, ld_err, busy, ins, ins_valid, ins_perr
    );
    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, req, addr, stall, par_inj,
        output ld_count, ld_err, busy, ins, ins_valid, ins_perr
    );
`else
    modport master (
        output ld_start, ld_valid, ld_data, ld_last, req, addr, stall,
        input  ld_count, ld_err, busy, ins, ins_valid, ins_perr
    );
    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, req, addr, stall,
        output ld_count, ld_err, busy, ins, ins_valid, ins_perr
    );
`endif
endinterface

// File: rtl/imem_sync_loader.sv
// Run-time loadable instruction memory with 1-cycle synchronous fetch.
// Optional stored parity per word when IMEM_PARITY_EN is defined.
module imem_sync_loader #(
    parameter int unsigned   W     = 8,
    parameter int unsigned   DEPTH = 32,
    parameter int unsigned   AW    = 8,
    parameter logic [W-1:0]  FILL  = W'(8'hC0)
) (
    input logic               clk,
    input logic               rst,
    imem_sync_loader_if.slave bus
);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned MW = W + 1;
`else
    localparam int unsigned MW = W;
`endif
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_RUN
    } state_t;

    state_t         state;
    logic [AW:0]    ld_count;
    logic           ld_err;
    logic [W-1:0]   ins;
    logic           ins_valid;
    logic           ins_perr;

    logic [MW-1:0]  mem [DEPTH];
    logic [MW-1:0]  wr_word;
    logic [MW-1:0]  rd_word;
    logic           wr_en;
    logic           room;
    logic           addr_ok;
    logic           rd_perr;

    assign room    = (ld_count < DEPTH_V);
    assign addr_ok = ({1'b0, bus.addr} < DEPTH_V);
    assign wr_en   = !rst && !bus.ld_start && (state == S_LOAD) && bus.ld_valid && room;
    assign rd_word = mem[IW'(bus.addr)];

`ifdef IMEM_PARITY_EN
    assign wr_word = {(^bus.ld_data) ^ bus.par_inj, bus.ld_data};
    assign rd_perr = (^rd_word[W-1:0]) != rd_word[W];
`else
    assign wr_word = bus.ld_data;
    assign rd_perr = 1'b0;
`endif

    // Array has no reset; stale words above ld_count are served as-is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[IW'(ld_count)] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            ld_count  <= '0;
            ld_err    <= 1'b0;
            ins       <= '0;
            ins_valid <= 1'b0;
            ins_perr  <= 1'b0;
        end else if (bus.ld_start) begin
            // Start wins over ld_valid, req and stall.
            state     <= S_LOAD;
            ld_count  <= '0;
            ld_err    <= 1'b0;
            ins_valid <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        if (room) begin
                            ld_count <= ld_count + (AW + 1)'(1);
                        end else begin
                            ld_err <= 1'b1;
                        end
                        if (bus.ld_last) begin
                            state <= S_RUN;
                        end
                    end
                    if (!bus.stall) begin
                        ins_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!bus.stall) begin
                        ins_valid <= bus.req;
                        if (bus.req) begin
                            ins      <= addr_ok ? rd_word[W-1:0] : FILL;
                            ins_perr <= addr_ok ? rd_perr : 1'b0;
                        end
                    end
                end
                default: begin
                    if (!bus.stall) begin
                        ins_valid <= bus.req;
                        if (bus.req) begin
                            ins      <= FILL;
                            ins_perr <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ld_count  = ld_count;
    assign bus.ld_err    = ld_err;
    assign bus.busy      = (state == S_LOAD);
    assign bus.ins       = ins;
    assign bus.ins_valid = ins_valid;
    assign bus.ins_perr  = ins_perr;

endmodule

// File: tb/tb_imem_sync_loader.sv
// Directed bench for imem_sync_loader; the parity case runs when IMEM_PARITY_EN is defined.
module tb_imem_sync_loader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    imem_sync_loader_if #(.W(8), .AW(8)) bus ();

    imem_sync_loader #(
        .W     (8),
        .DEPTH (32),
        .AW    (8),
        .FILL  (8'hC0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic last, input logic inj);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
`ifdef IMEM_PARITY_EN
        bus.par_inj  = inj;
`else
        if (inj) $display("note: par_inj ignored in this build");
`endif
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
`ifdef IMEM_PARITY_EN
        bus.par_inj  = 1'b0;
`endif
    endtask

    task automatic start_load();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        bus.req  = 1'b1;
        bus.addr = a;
        tick();
        bus.req  = 1'b0;
    endtask

    task automatic load_prog();
        logic [7:0] prog [4];
        prog = '{8'h48, 8'h49, 8'h65, 8'h1B};
        start_load();
        for (int i = 0; i < 4; i++) begin
            check("busy_during_load", 32'(bus.busy), 32'd1);
            push(prog[i], i == 3, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_data  = '0;
        bus.ld_last  = 1'b0;
        bus.req      = 1'b0;
        bus.addr     = '0;
        bus.stall    = 1'b0;
`ifdef IMEM_PARITY_EN
        bus.par_inj  = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        check("rst_ins",       32'(bus.ins),       32'h0);
        check("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_ins_perr",  32'(bus.ins_perr),  32'd0);
        check("rst_ld_count",  32'(bus.ld_count),  32'd0);
        check("rst_ld_err",    32'(bus.ld_err),    32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);

        // Fetch while EMPTY returns the fill word.
        fetch(8'd0);
        check("empty_ins",   32'(bus.ins),       32'hC0);
        check("empty_valid", 32'(bus.ins_valid), 32'd1);
        check("empty_busy",  32'(bus.busy),      32'd0);

        load_prog();
        check("load4_count", 32'(bus.ld_count), 32'd4);
        check("load4_busy",  32'(bus.busy),     32'd0);
        check("load4_err",   32'(bus.ld_err),   32'd0);
        fetch(8'd2);
        check("run_a2",       32'(bus.ins),       32'h65);
        check("run_a2_valid", 32'(bus.ins_valid), 32'd1);
        fetch(8'd0);
        check("run_a0", 32'(bus.ins), 32'h48);
        fetch(8'd3);
        check("run_a3", 32'(bus.ins), 32'h1B);

        // Out-of-range fetches.
        fetch(8'd40);
        check("oor40_ins",   32'(bus.ins),       32'hC0);
        check("oor40_valid", 32'(bus.ins_valid), 32'd1);
        check("oor40_perr",  32'(bus.ins_perr),  32'd0);
        fetch(8'd32);
        check("oor32_ins", 32'(bus.ins), 32'hC0);
        fetch(8'd255);
        check("oor255_ins", 32'(bus.ins), 32'hC0);
        tick();
        check("idle_valid", 32'(bus.ins_valid), 32'd0);
        check("idle_hold",  32'(bus.ins),       32'hC0);

        // ld_valid outside LOAD is ignored.
        push(8'hEE, 1'b1, 1'b0);
        check("run_ldv_count", 32'(bus.ld_count), 32'd4);
        fetch(8'd0);
        check("run_ldv_a0", 32'(bus.ins), 32'h48);

        // Stall holds the response while req/addr wiggle.
        fetch(8'd1);
        check("pre_stall_ins", 32'(bus.ins), 32'h49);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req  = (i != 1);
            bus.addr = 8'(i * 20);
            tick();
            check("stall_ins",   32'(bus.ins),       32'h49);
            check("stall_valid", 32'(bus.ins_valid), 32'd1);
        end
        bus.req   = 1'b0;
        bus.stall = 1'b0;

        // Overflowing load: 33 words into 32 entries.
        start_load();
        for (int i = 0; i < 32; i++) push(8'h80 + 8'(i), 1'b0, 1'b0);
        check("ovf_count32", 32'(bus.ld_count), 32'd32);
        check("ovf_err_pre", 32'(bus.ld_err),   32'd0);
        push(8'h11, 1'b1, 1'b0);
        check("ovf_count", 32'(bus.ld_count), 32'd32);
        check("ovf_err",   32'(bus.ld_err),   32'd1);
        check("ovf_busy",  32'(bus.busy),     32'd0);
        fetch(8'd31);
        check("ovf_a31", 32'(bus.ins), 32'h9F);
        fetch(8'd0);
        check("ovf_a0", 32'(bus.ins), 32'h80);

        // ld_start beats stall for ins_valid and clears ld_err.
        bus.stall    = 1'b1;
        bus.req      = 1'b1;
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.stall    = 1'b0;
        check("start_valid", 32'(bus.ins_valid), 32'd0);
        check("start_err",   32'(bus.ld_err),    32'd0);
        check("start_count", 32'(bus.ld_count),  32'd0);
        check("start_busy",  32'(bus.busy),      32'd1);
        bus.addr = 8'd1;
        tick();
        check("load_req_valid", 32'(bus.ins_valid), 32'd0);
        check("load_req_hold",  32'(bus.ins),       32'h80);
        bus.req = 1'b0;

        // Restart while loading resets the pointer.
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        check("restart_pre", 32'(bus.ld_count), 32'd2);
        load_prog();
        check("restart_count", 32'(bus.ld_count), 32'd4);
        fetch(8'd1);
        check("restart_a1", 32'(bus.ins), 32'h49);

        // Reset mid-load returns to EMPTY.
        start_load();
        push(8'hAA, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",  32'(bus.busy),     32'd0);
        check("midrst_count", 32'(bus.ld_count), 32'd0);
        fetch(8'd0);
        check("midrst_fill", 32'(bus.ins), 32'hC0);

`ifdef IMEM_PARITY_EN
        start_load();
        push(8'h48, 1'b0, 1'b0);
        push(8'h49, 1'b0, 1'b0);
        push(8'h65, 1'b0, 1'b0);
        push(8'h1B, 1'b1, 1'b1);
        fetch(8'd3);
        check("par_a3_ins",  32'(bus.ins),      32'h1B);
        check("par_a3_perr", 32'(bus.ins_perr), 32'd1);
        fetch(8'd2);
        check("par_a2_perr", 32'(bus.ins_perr), 32'd0);
        fetch(8'd3);
        check("par_a3_again", 32'(bus.ins_perr), 32'd1);
        fetch(8'd40);
        check("par_fill_perr", 32'(bus.ins_perr), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
